// File: rtl/bldc_hall_emulator.sv
// ---------------------------------------------------------------------------
// bldc_hall_emulator
//
// Closed-loop BLDC motor / Hall-sensor emulator. It watches the six-switch
// phase drive of a commutation driver and returns the Hall code the driver
// expects. The rotor advances one sector per step_ticks cycles of effective
// (PWM-on, correctly commutated) drive.
//
// Optional build macro:
//   BLDC_HALL_EMU_GLITCH_EN - when defined, each sector step makes
//   hall_values bounce between the old and new codes for glitch_cycles
//   cycles before settling on the new code.
//
// Parameters:
//   clk_freq_hz    sys_clk frequency (documentation only)
//   counter_width  width of step accumulator, stall counter, step_count
//   init_sector    rotor sector after reset (0..5)
//   glitch_cycles  Hall bounce length in cycles (glitch build only)
//
// Ports:
//   sys_clk        system clock
//   reset_n        asynchronous active-low reset
//   phase_enable   [5:3] A/B/C high-side, [2:0] A/B/C low-side (async)
//   pwm_out        PWM-gated switch states, same layout (async)
//   enable         emulator enable
//   step_ticks     effective cycles per sector step (0 behaves as 1)
//   stall_limit    wrong-vector cycles before stall (0 disables stall)
//   fault_clear    single-cycle pulse clearing a latched fault
//   hall_values    emulated Hall code {H3,H2,H1}
//   fault_n        shoot-through fault, active low
//   overcurrent_n  stall overcurrent, active low
//   sector         true rotor sector 0..5
//   step_count     signed, wrapping count of sector steps
//   emu_state      0 IDLE, 1 RUN, 2 STALL, 3 FAULT
// ---------------------------------------------------------------------------
module bldc_hall_emulator #(
    parameter int unsigned clk_freq_hz   = 54_000_000,
    parameter int          counter_width = 32,
    parameter int          init_sector   = 0,
    parameter int          glitch_cycles = 8
) (
    input  logic                     sys_clk,
    input  logic                     reset_n,
    input  logic [5:0]               phase_enable,
    input  logic [5:0]               pwm_out,
    input  logic                     enable,
    input  logic [counter_width-1:0] step_ticks,
    input  logic [counter_width-1:0] stall_limit,
    input  logic                     fault_clear,
    output logic [2:0]               hall_values,
    output logic                     fault_n,
    output logic                     overcurrent_n,
    output logic [2:0]               sector,
    output logic [counter_width-1:0] step_count,
    output logic [1:0]               emu_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_FAULT = 2'd3
    } emu_state_t;

    localparam logic [2:0]               INIT_SECTOR = 3'(init_sector);
    localparam logic [counter_width-1:0] ONE         = {{(counter_width-1){1'b0}}, 1'b1};
    localparam logic [counter_width:0]   ONE_W       = {{counter_width{1'b0}}, 1'b1};

    // Elaboration-time sanity check of the configuration.
    if (init_sector < 0 || init_sector > 5 || clk_freq_hz == 0 || glitch_cycles < 0) begin : g_param_check
        $error("bldc_hall_emulator: illegal parameter value");
    end

    function automatic logic [2:0] hall_code(input logic [2:0] s);
        case (s)
            3'd0:    hall_code = 3'b001;
            3'd1:    hall_code = 3'b011;
            3'd2:    hall_code = 3'b010;
            3'd3:    hall_code = 3'b110;
            3'd4:    hall_code = 3'b100;
            3'd5:    hall_code = 3'b101;
            default: hall_code = 3'b000;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // 2-FF synchronisers. Only the high-side PWM bits gate the drive, the
    // low-side PWM bits are carried through but not decoded.
    // ------------------------------------------------------------------
    logic [5:0] pe_meta, pe_sync;
    logic [5:0] pwm_meta, pwm_sync;

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of the others, exactly like flip-flops.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            pe_meta  <= '0;
            pe_sync  <= '0;
            pwm_meta <= '0;
            pwm_sync <= '0;
        end else begin
            pe_meta  <= phase_enable;
            pe_sync  <= pe_meta;
            pwm_meta <= pwm_out;
            pwm_sync <= pwm_meta;
        end
    end

    wire unused_pwm_lo = ^pwm_sync[2:0];

    // ------------------------------------------------------------------
    // Drive decode
    // ------------------------------------------------------------------
    logic [2:0] drv_hi, drv_lo;
    logic       shoot, coast, vec_valid, effective;
    logic [2:0] vec_idx, rev_idx;
    logic       match_fwd, match_rev, vec_wrong;

    assign drv_hi    = pe_sync[5:3];
    assign drv_lo    = pe_sync[2:0];
    assign shoot     = |(drv_hi & drv_lo);
    assign coast     = (pe_sync == 6'd0);
    assign vec_valid = $onehot(drv_hi) && $onehot(drv_lo) && (drv_hi != drv_lo);
    assign effective = vec_valid && (|(pwm_sync[5:3] & drv_hi));

    always_comb begin
        case ({drv_hi, drv_lo})
            6'b100_010: vec_idx = 3'd0;  // A+ B-
            6'b100_001: vec_idx = 3'd1;  // A+ C-
            6'b010_001: vec_idx = 3'd2;  // B+ C-
            6'b010_100: vec_idx = 3'd3;  // B+ A-
            6'b001_100: vec_idx = 3'd4;  // C+ A-
            6'b001_010: vec_idx = 3'd5;  // C+ B-
            default:    vec_idx = 3'd0;
        endcase
    end

    // Reverse rotation is driven by the vector half a turn away.
    assign rev_idx   = (sector >= 3'd3) ? (sector - 3'd3) : (sector + 3'd3);
    assign match_fwd = vec_valid && (vec_idx == sector);
    assign match_rev = vec_valid && (vec_idx == rev_idx);
    assign vec_wrong = vec_valid && !match_fwd && !match_rev;

    // ------------------------------------------------------------------
    // State machine and step accumulator
    // ------------------------------------------------------------------
    emu_state_t                 state, state_next;
    logic [counter_width-1:0]   acc, acc_next, acc_base;
    logic [counter_width-1:0]   stall_cnt, stall_next;
    logic                       last_rev, last_rev_next;
    logic [counter_width:0]     ticks_eff, acc_inc, stall_inc;
    logic                       step_en, step_rev;
    logic [2:0]                 sector_step, sector_next;

    assign ticks_eff = (step_ticks == '0) ? ONE_W : {1'b0, step_ticks};
    // A direction change restarts accumulation from zero.
    assign acc_base  = (match_rev != last_rev) ? '0 : acc;
    assign acc_inc   = {1'b0, acc_base} + ONE_W;
    assign stall_inc = {1'b0, stall_cnt} + ONE_W;

    // NOTE: every signal driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        acc_next      = acc;
        stall_next    = stall_cnt;
        last_rev_next = last_rev;
        step_en       = 1'b0;
        step_rev      = 1'b0;

        if (shoot) begin
            state_next = ST_FAULT;
        end else begin
            case (state)
                ST_IDLE: begin
                    acc_next   = '0;
                    stall_next = '0;
                    if (enable) state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_next = ST_IDLE;
                    end else if (match_fwd || match_rev) begin
                        stall_next = '0;
                        if (effective) begin
                            last_rev_next = match_rev;
                            if (acc_inc >= ticks_eff) begin
                                step_en  = 1'b1;
                                step_rev = match_rev;
                                acc_next = '0;
                            end else begin
                                acc_next = acc_inc[counter_width-1:0];
                            end
                        end
                    end else if (vec_wrong) begin
                        stall_next = stall_inc[counter_width-1:0];
                        if ((stall_limit != '0) && (stall_inc >= {1'b0, stall_limit}))
                            state_next = ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (!enable) begin
                        state_next = ST_IDLE;
                    end else if (coast || match_fwd || match_rev) begin
                        state_next = ST_RUN;
                        stall_next = '0;
                    end
                end
                ST_FAULT: begin
                    // Shoot-through is already known absent on this branch.
                    if (fault_clear) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        if (step_rev) sector_step = (sector == 3'd0) ? 3'd5 : (sector - 3'd1);
        else          sector_step = (sector == 3'd5) ? 3'd0 : (sector + 3'd1);
    end

    assign sector_next = step_en ? sector_step : sector;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            acc           <= '0;
            stall_cnt     <= '0;
            last_rev      <= 1'b0;
            sector        <= INIT_SECTOR;
            step_count    <= '0;
            fault_n       <= 1'b1;
            overcurrent_n <= 1'b1;
        end else begin
            state         <= state_next;
            acc           <= acc_next;
            stall_cnt     <= stall_next;
            last_rev      <= last_rev_next;
            sector        <= sector_next;
            if (step_en)
                step_count <= step_rev ? (step_count - ONE) : (step_count + ONE);
            fault_n       <= (state_next != ST_FAULT);
            overcurrent_n <= (state_next != ST_STALL);
        end
    end

    assign emu_state = state;

    // ------------------------------------------------------------------
    // Hall output
    // ------------------------------------------------------------------
`ifdef BLDC_HALL_EMU_GLITCH_EN
    localparam int GW = (glitch_cycles < 2) ? 1 : $clog2(glitch_cycles + 1);
    localparam logic [GW-1:0] BOUNCE_LOAD = (glitch_cycles > 0) ? GW'(glitch_cycles - 1) : '0;

    logic [GW-1:0] bounce_cnt;
    logic [2:0]    bounce_old;

    // The first bounce cycle shows the new code, then it alternates with
    // the code that was on the pins when the step arrived.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            hall_values <= hall_code(INIT_SECTOR);
            bounce_old  <= hall_code(INIT_SECTOR);
            bounce_cnt  <= '0;
        end else if (step_en) begin
            bounce_old  <= hall_values;
            hall_values <= hall_code(sector_step);
            bounce_cnt  <= BOUNCE_LOAD;
        end else if (bounce_cnt != '0) begin
            bounce_cnt  <= bounce_cnt - GW'(1);
            hall_values <= (hall_values == hall_code(sector)) ? bounce_old : hall_code(sector);
        end else begin
            hall_values <= hall_code(sector);
        end
    end
`else
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) hall_values <= hall_code(INIT_SECTOR);
        else          hall_values <= hall_code(sector_next);
    end
`endif

endmodule

// File: tb/tb_bldc_hall_emulator.sv
// ---------------------------------------------------------------------------
// tb_bldc_hall_emulator
//
// Self-checking bench for bldc_hall_emulator (default build). A driver
// process applies directed and random drive patterns on the falling edge,
// advances a behavioural rotor model for the coming rising edge and queues
// the expected outputs. A monitor pops one expectation per rising edge and
// compares it with the DUT outputs shortly after the edge.
// ---------------------------------------------------------------------------
module tb_bldc_hall_emulator;

    localparam int CW = 32;

    logic          sys_clk = 1'b0;
    logic          reset_n;
    logic [5:0]    phase_enable, pwm_out;
    logic          enable, fault_clear;
    logic [CW-1:0] step_ticks, stall_limit;
    logic [2:0]    hall_values, sector;
    logic          fault_n, overcurrent_n;
    logic [CW-1:0] step_count;
    logic [1:0]    emu_state;

    bldc_hall_emulator #(
        .clk_freq_hz  (54_000_000),
        .counter_width(CW),
        .init_sector  (0),
        .glitch_cycles(8)
    ) dut (
        .sys_clk      (sys_clk),
        .reset_n      (reset_n),
        .phase_enable (phase_enable),
        .pwm_out      (pwm_out),
        .enable       (enable),
        .step_ticks   (step_ticks),
        .stall_limit  (stall_limit),
        .fault_clear  (fault_clear),
        .hall_values  (hall_values),
        .fault_n      (fault_n),
        .overcurrent_n(overcurrent_n),
        .sector       (sector),
        .step_count   (step_count),
        .emu_state    (emu_state)
    );

    always #5 sys_clk = ~sys_clk;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [2:0]    sector;
        logic [2:0]    hall;
        logic          fault_n;
        logic          oc_n;
        logic [CW-1:0] count;
        logic [1:0]    st;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural rotor model
    // ------------------------------------------------------------------
    // Vector index i drives phase pair_hi[i] high and pair_lo[i] low
    // (phase 0 = A, 1 = B, 2 = C).
    int pair_hi [6] = '{0, 0, 1, 1, 2, 2};
    int pair_lo [6] = '{1, 2, 2, 0, 0, 1};
    int hall_tab[6] = '{1, 3, 2, 6, 4, 5};

    int m_sector, m_count, m_acc, m_stall, m_mode, m_dir;  // m_mode: 0 idle 1 run 2 stall 3 fault
    logic [5:0] pe_dly[$], pwm_dly[$];
    int cur_ticks, cur_limit;

    function automatic logic [5:0] vec(input int i);
        int word;
        word = (1 << (5 - pair_hi[i])) | (1 << (2 - pair_lo[i]));
        return word[5:0];
    endfunction

    task automatic model_reset();
        m_sector = 0;
        m_count  = 0;
        m_acc    = 0;
        m_stall  = 0;
        m_mode   = 0;
        m_dir    = 0;
        pe_dly   = '{6'd0, 6'd0};
        pwm_dly  = '{6'd0, 6'd0};
    endtask

    task automatic model_step(input logic [5:0] pe_in, input logic [5:0] pwm_in,
                              input logic en, input logic fc, input int ticks, input int limit);
        logic [5:0] pe, pwm;
        int nhi, nlo, hp, lp, idx, d;
        bit shoot, eff, valid, coast;
        // The drive seen by the rotor lags the pins by two clock edges.
        pe  = pe_dly.pop_front();
        pwm = pwm_dly.pop_front();
        pe_dly.push_back(pe_in);
        pwm_dly.push_back(pwm_in);

        nhi = 0; nlo = 0; hp = -1; lp = -1; shoot = 0; eff = 0;
        for (int p = 0; p < 3; p++) begin
            if (pe[5-p]) begin nhi++; hp = p; if (pwm[5-p]) eff = 1; end
            if (pe[2-p]) begin nlo++; lp = p; end
            if (pe[5-p] && pe[2-p]) shoot = 1;
        end
        valid = (nhi == 1) && (nlo == 1) && (hp != lp);
        coast = (pe == 6'd0);
        idx = -1;
        if (valid)
            for (int i = 0; i < 6; i++)
                if (pair_hi[i] == hp && pair_lo[i] == lp) idx = i;
        d = 0;
        if (valid && idx == m_sector)                d = 1;
        else if (valid && idx == (m_sector + 3) % 6) d = -1;

        if (shoot) begin
            m_mode = 3;
        end else begin
            case (m_mode)
                0: begin
                    m_acc = 0; m_stall = 0;
                    if (en) m_mode = 1;
                end
                1: begin
                    if (!en) m_mode = 0;
                    else if (d != 0) begin
                        m_stall = 0;
                        if (eff) begin
                            if (d != m_dir) m_acc = 0;
                            m_dir = d;
                            if (m_acc + 1 >= ((ticks < 1) ? 1 : ticks)) begin
                                m_sector = (m_sector + d + 6) % 6;
                                m_count += d;
                                m_acc = 0;
                            end else begin
                                m_acc++;
                            end
                        end
                    end else if (valid) begin
                        m_stall++;
                        if (limit != 0 && m_stall >= limit) m_mode = 2;
                    end
                end
                2: begin
                    if (!en) m_mode = 0;
                    else if (coast || d != 0) begin m_mode = 1; m_stall = 0; end
                end
                default: if (fc) m_mode = 0;
            endcase
        end
    endtask

    // One clock of stimulus: drive on the falling edge, predict the rising edge.
    task automatic cycle(input logic rst, input logic [5:0] pe, input logic [5:0] pwm,
                         input logic en, input logic fc);
        exp_t e;
        @(negedge sys_clk);
        reset_n      = !rst;
        phase_enable = pe;
        pwm_out      = pwm;
        enable       = en;
        fault_clear  = fc;
        step_ticks   = CW'(cur_ticks);
        stall_limit  = CW'(cur_limit);
        if (rst) model_reset();
        else     model_step(pe, pwm, en, fc, cur_ticks, cur_limit);
        e.sector  = 3'(m_sector);
        e.hall    = 3'(hall_tab[m_sector]);
        e.fault_n = (m_mode != 3);
        e.oc_n    = (m_mode != 2);
        e.count   = CW'(m_count);
        e.st      = 2'(m_mode);
        exp_q.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sector",        64'(sector),        64'(e.sector));
                check("hall_values",   64'(hall_values),   64'(e.hall));
                check("fault_n",       64'(fault_n),       64'(e.fault_n));
                check("overcurrent_n", 64'(overcurrent_n), 64'(e.oc_n));
                check("step_count",    64'(step_count),    64'(e.count));
                check("emu_state",     64'(emu_state),     64'(e.st));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [5:0] pe;
        logic       en;
        int         hold;

        reset_n = 1'b0; phase_enable = '0; pwm_out = '0; enable = 1'b0; fault_clear = 1'b0;
        cur_ticks = 100; cur_limit = 50;
        step_ticks = CW'(cur_ticks); stall_limit = CW'(cur_limit);
        model_reset();

        repeat (3) cycle(1, 6'd0, 6'd0, 0, 0);
        repeat (4) cycle(0, 6'd0, 6'd0, 0, 0);

        // Forward drive, full PWM: one step per 100 cycles.
        repeat (640) cycle(0, vec(m_sector), 6'h3f, 1, 0);
        // Forward drive, roughly half duty on the high side.
        repeat (500) cycle(0, vec(m_sector), ($urandom_range(0, 1) != 0) ? 6'h38 : 6'h00, 1, 0);
        // Reverse drive.
        repeat (450) cycle(0, vec((m_sector + 3) % 6), 6'h3f, 1, 0);

        // Wrong vector until stall, then recover with the correct one.
        repeat (80) cycle(0, vec((m_sector + 2) % 6), 6'h3f, 1, 0);
        repeat (10) cycle(0, vec(m_sector), 6'h3f, 1, 0);
        // stall_limit of zero never stalls.
        cur_limit = 0;
        repeat (80) cycle(0, vec((m_sector + 2) % 6), 6'h3f, 1, 0);
        cur_limit = 50;
        repeat (5) cycle(0, vec(m_sector), 6'h3f, 1, 0);

        // Shoot-through on phase A, clear attempts while shorted and after.
        repeat (5) cycle(0, 6'b100100, 6'h3f, 1, 0);
        cycle(0, 6'b100100, 6'h3f, 1, 1);
        repeat (3) cycle(0, 6'b100100, 6'h3f, 1, 0);
        repeat (4) cycle(0, 6'd0, 6'd0, 1, 0);
        cycle(0, 6'd0, 6'd0, 0, 1);
        repeat (3) cycle(0, 6'd0, 6'd0, 0, 0);

        // step_ticks of zero behaves as one.
        cur_ticks = 0;
        repeat (20) cycle(0, vec(m_sector), 6'h3f, 1, 0);

        // Random closed-loop stimulus with a reset in the middle.
        cur_ticks = 3; cur_limit = 6; en = 1'b1; pe = 6'd0; hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) en = !en;
            if ($urandom_range(0, 299) == 0) cur_ticks = $urandom_range(0, 6);
            if ($urandom_range(0, 299) == 0) cur_limit = $urandom_range(0, 12);
            if (hold == 0) begin
                int sel;
                sel  = $urandom_range(0, 39);
                hold = $urandom_range(1, 8);
                if      (sel < 16) pe = vec(m_sector);
                else if (sel < 24) pe = vec((m_sector + 3) % 6);
                else if (sel < 32) pe = vec($urandom_range(0, 5));
                else if (sel < 38) pe = 6'd0;
                else               pe = 6'($urandom);
            end
            hold--;
            cycle((i >= 1500 && i < 1502), pe, 6'($urandom), en, ($urandom_range(0, 7) == 0));
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge sys_clk);
        #2;
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
